// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial binary-to-BCD converter.
package bcd_pkg;

  localparam int DIGITO_W    = 4;
  localparam int MAX_DIGITOS = 16;

  typedef enum logic {
    OCIOSO,
    CONVERTE
  } estado_t;

  // Leading-zero mask over up to MAX_DIGITOS packed digits; callers zero-pad
  // unused upper digits and keep the low bits they need. Bit 0 is never set.
  function automatic logic [MAX_DIGITOS-1:0] zeros_esquerda(
    input logic [DIGITO_W*MAX_DIGITOS-1:0] digits
  );
    logic                   run;
    logic [MAX_DIGITOS-1:0] m;
    run = 1'b1;
    m   = '0;
    for (int i = MAX_DIGITOS - 1; i >= 1; i--) begin
      run  = run & (digits[DIGITO_W*i +: DIGITO_W] == '0);
      m[i] = run;
    end
    return m;
  endfunction

endpackage

// File: rtl/bcd_ajuste_digito.sv
// Add-3 correction for one BCD digit ahead of the left shift.
module bcd_ajuste_digito
  import bcd_pkg::*;
(
  input  logic [DIGITO_W-1:0] entrada,
  output logic [DIGITO_W-1:0] saida
);

  assign saida = (entrada >= DIGITO_W'(5)) ? entrada + DIGITO_W'(3) : entrada;

endmodule

// File: rtl/bcd_serial_n_digitos.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with sign handling, sticky overflow and a leading-zero blanking mask.
module bcd_serial_n_digitos
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 4,   // at most MAX_DIGITOS
  parameter bit SIGNED = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           numero,
  output logic                       busy,
  output logic                       valid,
  output logic                       sinal,
  output logic [DIGITO_W*DIGITS-1:0] digitos,
  output logic                       overflow,
  output logic [DIGITS-1:0]          zeros_esq
);

  localparam int BW = DIGITO_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  estado_t                         estado;
  logic [CW-1:0]                   cont;
  logic [WIDTH-1:0]                mag;
  logic [BW-1:0]                   bcd;
  logic                            ovf_int;
  logic                            sinal_int;

  logic [BW-1:0]                   adj;
  logic [BW-1:0]                   bcd_next;
  logic [WIDTH-1:0]                mag_next;
  logic                            ovf_next;
  logic [DIGITO_W*MAX_DIGITOS-1:0] bcd_pad;
  logic [MAX_DIGITOS-1:0]          zmask;
  logic [DIGITS-1:0]               zeros_next;
  logic                            neg;

  for (genvar i = 0; i < DIGITS; i++) begin : g_ajuste
    bcd_ajuste_digito u_ajuste (
      .entrada (bcd[DIGITO_W*i +: DIGITO_W]),
      .saida   (adj[DIGITO_W*i +: DIGITO_W])
    );
  end

  assign neg  = SIGNED & numero[WIDTH-1];
  assign busy = (estado == CONVERTE);

  // NOTE: every signal is assigned before any conditional use, so no latch is inferred.
  always_comb begin
    bcd_next           = {adj[BW-2:0], mag[WIDTH-1]};
    mag_next           = {mag[WIDTH-2:0], 1'b0};
    ovf_next           = ovf_int | adj[BW-1];
    bcd_pad            = '0;
    bcd_pad[BW-1:0]    = bcd_next;
    zmask              = zeros_esquerda(bcd_pad);
    zeros_next         = zmask[DIGITS-1:0];
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      cont      <= '0;
      mag       <= '0;
      bcd       <= '0;
      ovf_int   <= 1'b0;
      sinal_int <= 1'b0;
      valid     <= 1'b0;
      sinal     <= 1'b0;
      digitos   <= '0;
      overflow  <= 1'b0;
      zeros_esq <= '0;
    end else begin
      valid <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (start) begin
            // Two's complement of the most negative value wraps to 2^(WIDTH-1),
            // which is the correct unsigned magnitude.
            sinal_int <= neg;
            mag       <= neg ? (~numero + WIDTH'(1)) : numero;
            bcd       <= '0;
            ovf_int   <= 1'b0;
            cont      <= CW'(WIDTH);
            estado    <= CONVERTE;
          end
        end
        CONVERTE: begin
          bcd     <= bcd_next;
          mag     <= mag_next;
          ovf_int <= ovf_next;
          cont    <= cont - CW'(1);
          if (cont == CW'(1)) begin
            digitos   <= bcd_next;
            overflow  <= ovf_next;
            sinal     <= sinal_int;
            zeros_esq <= zeros_next;
            valid     <= 1'b1;
            estado    <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
